// File: rtl/bsg_two_fifo_arst.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo_arst
//
// Two-entry ready/valid FIFO that sits in front of the registered datapath
// stage. It decouples producer and consumer backpressure. Both ready_o and
// v_o come straight from state flags, so no input reaches them
// combinationally. With two entries the FIFO still sustains one word per
// cycle under continuous flow.
//
// Ports
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset; clears pointers, flags, storage
//   v_i        : producer presents a valid word on data_i
//   data_i     : write data, width_p bits
//   ready_o    : FIFO can accept a word this cycle (not full)
//   v_o        : data_o holds a valid word (not empty)
//   data_o     : oldest stored word, read directly from storage
//   yumi_i     : consumer takes data_o this cycle (legal only while v_o=1)
// ---------------------------------------------------------------------------
module bsg_two_fifo_arst #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem [2];
  logic               wptr;
  logic               rptr;
  logic               empty_r;
  logic               full_r;

  logic               enq;
  logic               deq;

  // A yumi_i with nothing stored is a protocol violation. Masking it with
  // ~empty_r keeps the pointers and flags unchanged when it happens.
  assign enq = v_i & ~full_r;
  assign deq = yumi_i & ~empty_r;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem[rptr];

  // NOTE: the storage entries sit in the reset branch on purpose. data_o is
  // read straight from mem, and it must show 0 while in reset. That rules out
  // a reset-less RAM for this block.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values. A simultaneous enq/deq therefore sees a consistent
      // occupancy, whatever order the statements appear in.
      if (enq) begin
        mem[wptr] <= data_i;
        wptr      <= ~wptr;
      end

      if (deq) begin
        rptr <= ~rptr;
      end

      // Occupancy moves only when exactly one side is active. An enq together
      // with a deq in ONE leaves both flags alone.
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= ~empty_r;   // ONE -> FULL, EMPTY -> ONE
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= ~full_r;    // ONE -> EMPTY, FULL -> ONE
      end
    end
  end

endmodule
